// File: rtl/sd_cmd_resp_receiver_if.sv
// ---------------------------------------------------------------------------
// sd_cmd_resp_receiver_if
//   Bundles the control, CMD-line sample and result signals of the SD
//   command-response receiver.
//   master : controller side (drives strobe/CMD/control, reads results)
//   slave  : receiver side
//   Control  : SAMPLE_EN, CMD_I, START, LONG, CHECK_CRC, ABORT
//   Results  : BUSY, DONE, INDEX[5:0], RESP[127:0],
//              CRC_ERR, END_ERR, TX_ERR, TIMEOUT_ERR
// ---------------------------------------------------------------------------
interface sd_cmd_resp_receiver_if;
    logic         SAMPLE_EN;
    logic         CMD_I;
    logic         START;
    logic         LONG;
    logic         CHECK_CRC;
    logic         ABORT;
    logic         BUSY;
    logic         DONE;
    logic [5:0]   INDEX;
    logic [127:0] RESP;
    logic         CRC_ERR;
    logic         END_ERR;
    logic         TX_ERR;
    logic         TIMEOUT_ERR;

    modport master (
        output SAMPLE_EN, CMD_I, START, LONG, CHECK_CRC, ABORT,
        input  BUSY, DONE, INDEX, RESP, CRC_ERR, END_ERR, TX_ERR, TIMEOUT_ERR
    );

    modport slave (
        input  SAMPLE_EN, CMD_I, START, LONG, CHECK_CRC, ABORT,
        output BUSY, DONE, INDEX, RESP, CRC_ERR, END_ERR, TX_ERR, TIMEOUT_ERR
    );
endinterface

// File: rtl/sd_cmd_resp_receiver.sv
// ---------------------------------------------------------------------------
// sd_cmd_resp_receiver
//   Receives an SD card response on the CMD line. After START it waits for
//   a start bit (bounded by TIMEOUT strobes), deserializes a 48-bit or
//   136-bit (R2) frame, checks transmission bit, CRC7 and end bit, and
//   pulses DONE with the result. All sampling is qualified by SAMPLE_EN.
//   Ports:
//     CLK  : system clock, posedge
//     RST  : asynchronous, active-high reset
//     bus  : slave side of sd_cmd_resp_receiver_if (control in, results out)
//   Parameter:
//     TIMEOUT : SAMPLE_EN strobes without a start bit before TIMEOUT_ERR
// ---------------------------------------------------------------------------
module sd_cmd_resp_receiver #(
    parameter int TIMEOUT = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    sd_cmd_resp_receiver_if.slave  bus
);
    localparam int              TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RECV   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]      r_state;
    logic            r_long;
    logic            r_check_crc;
    logic [7:0]      r_bit_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [6:0]      r_crc;
    logic [6:0]      r_crc_rx;
    logic [5:0]      r_index;
    logic [127:0]    r_resp;
    logic            r_crc_err;
    logic            r_end_err;
    logic            r_tx_err;
    logic            r_to_err;

    logic [7:0]      w_bit_num;
    logic [TO_W-1:0] w_to_next;
    logic            w_last;
    logic            w_crc_cov;
    logic [6:0]      w_crc_next;
    logic [6:0]      w_crc_rx_cmp;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Frame bit number of the bit being sampled now (start bit is bit 1)
    assign w_bit_num = r_bit_cnt + 8'd1;
    assign w_to_next = r_to_cnt + TO_W'(1);
    assign w_last    = r_long ? (w_bit_num == 8'd136) : (w_bit_num == 8'd48);
    // Long frames protect only RESP[127:8] (frame bits 9-128); the header is excluded
    assign w_crc_cov = r_long ? ((w_bit_num >= 8'd9) && (w_bit_num <= 8'd128))
                              : (w_bit_num <= 8'd40);
    assign w_crc_next = crc7_step(r_crc, bus.CMD_I);
    // For a long frame the received CRC sits in RESP[6:0] just before the end bit shifts in
    assign w_crc_rx_cmp = r_long ? r_resp[6:0] : r_crc_rx;

    assign bus.BUSY        = (r_state == S_WAIT) || (r_state == S_RECV);
    assign bus.DONE        = (r_state == S_FINISH) && !bus.ABORT;
    assign bus.INDEX       = r_index;
    assign bus.RESP        = r_resp;
    assign bus.CRC_ERR     = r_crc_err;
    assign bus.END_ERR     = r_end_err;
    assign bus.TX_ERR      = r_tx_err;
    assign bus.TIMEOUT_ERR = r_to_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_long      <= 1'b0;
            r_check_crc <= 1'b0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_crc       <= '0;
            r_crc_rx    <= '0;
            r_index     <= '0;
            r_resp      <= '0;
            r_crc_err   <= 1'b0;
            r_end_err   <= 1'b0;
            r_tx_err    <= 1'b0;
            r_to_err    <= 1'b0;
        end else if (bus.ABORT) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_long      <= bus.LONG;
                        r_check_crc <= bus.CHECK_CRC;
                        r_bit_cnt   <= '0;
                        r_to_cnt    <= '0;
                        r_crc       <= '0;
                        r_crc_rx    <= '0;
                        r_index     <= '0;
                        r_resp      <= '0;
                        r_crc_err   <= 1'b0;
                        r_end_err   <= 1'b0;
                        r_tx_err    <= 1'b0;
                        r_to_err    <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.SAMPLE_EN) begin
                        if (!bus.CMD_I) begin
                            r_crc     <= w_crc_next;
                            r_bit_cnt <= 8'd1;
                            r_state   <= S_RECV;
                        end else begin
                            r_to_cnt <= w_to_next;
                            if (w_to_next == TO_MAX) begin
                                r_to_err <= 1'b1;
                                r_state  <= S_FINISH;
                            end
                        end
                    end
                end
                S_RECV: begin
                    if (bus.SAMPLE_EN) begin
                        r_bit_cnt <= w_bit_num;
                        if (w_crc_cov)
                            r_crc <= w_crc_next;
                        if ((w_bit_num == 8'd2) && bus.CMD_I)
                            r_tx_err <= 1'b1;
                        if ((w_bit_num >= 8'd3) && (w_bit_num <= 8'd8))
                            r_index <= {r_index[4:0], bus.CMD_I};
                        if (r_long) begin
                            if (w_bit_num >= 8'd9)
                                r_resp <= {r_resp[126:0], bus.CMD_I};
                        end else begin
                            if ((w_bit_num >= 8'd9) && (w_bit_num <= 8'd40))
                                r_resp[31:0] <= {r_resp[30:0], bus.CMD_I};
                            if ((w_bit_num >= 8'd41) && (w_bit_num <= 8'd47))
                                r_crc_rx <= {r_crc_rx[5:0], bus.CMD_I};
                        end
                        if (w_last) begin
                            r_end_err <= !bus.CMD_I;
                            r_crc_err <= r_check_crc && (w_crc_rx_cmp != r_crc);
                            r_state   <= S_FINISH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_resp_receiver.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_resp_receiver
//   Directed and randomized frames for sd_cmd_resp_receiver. Expected
//   results come from frame fields and a long-division CRC7 reference.
// ---------------------------------------------------------------------------
module tb_sd_cmd_resp_receiver;
    logic CLK = 1'b0;
    logic RST;

    sd_cmd_resp_receiver_if bus();

    sd_cmd_resp_receiver #(.TIMEOUT(64)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int unsigned errors   = 0;
    int unsigned checks   = 0;
    int unsigned done_cnt = 0;
    int unsigned d0       = 0;

    // DONE pulses counted mid-cycle, well clear of both clock edges
    always @(negedge CLK) begin
        #2;
        if (bus.DONE === 1'b1) done_cnt++;
    end

    logic [135:0] fvec;
    int           fn;
    logic [5:0]   e_idx;
    logic         e_chk_idx;
    logic [127:0] e_resp;
    logic         e_crc, e_end, e_tx, e_to;

    logic         r_lng, r_chk, r_tx, r_endb;
    logic [6:0]   r_flip;
    logic [119:0] r_pay;
    int           r_div, r_pre;

    function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
        logic [126:0] w;
        w = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
        return w[6:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prep_short(input logic tx, input logic [5:0] idx, input logic [31:0] arg,
                              input logic [6:0] flip, input logic endb, input logic chk_crc);
        logic [6:0] good;
        good      = crc7_ref(120'({1'b0, tx, idx, arg}), 40);
        fvec      = 136'({1'b0, tx, idx, arg, good ^ flip, endb});
        fn        = 48;
        e_idx     = idx;
        e_chk_idx = 1'b1;
        e_resp    = {96'b0, arg};
        e_tx      = tx;
        e_end     = !endb;
        e_crc     = chk_crc && (flip != 7'd0);
        e_to      = 1'b0;
    endtask

    task automatic prep_long(input logic tx, input logic [119:0] pay, input logic [6:0] flip,
                             input logic endb, input logic chk_crc);
        logic [6:0] good;
        good      = crc7_ref(pay, 120);
        e_resp    = {pay, good ^ flip, endb};
        fvec      = {1'b0, tx, 6'h3F, e_resp};
        fn        = 136;
        e_idx     = 6'h3F;
        e_chk_idx = 1'b0;
        e_tx      = tx;
        e_end     = !endb;
        e_crc     = chk_crc && (flip != 7'd0);
        e_to      = 1'b0;
    endtask

    task automatic drive_bit(input logic b, input int div);
        repeat (div - 1) begin
            @(negedge CLK);
            bus.SAMPLE_EN = 1'b0;
            bus.CMD_I     = 1'($urandom);
        end
        @(negedge CLK);
        bus.SAMPLE_EN = 1'b1;
        bus.CMD_I     = b;
    endtask

    task automatic drive_range(input int from, input int to, input int div);
        for (int k = from; k <= to; k++) drive_bit(fvec[fn - k], div);
    endtask

    // START pulse carries a zero strobe too: it must not count as a start bit
    task automatic arm(input logic lng, input logic chk_crc);
        d0 = done_cnt;
        @(negedge CLK);
        bus.START = 1'b1; bus.LONG = lng; bus.CHECK_CRC = chk_crc;
        bus.SAMPLE_EN = 1'b1; bus.CMD_I = 1'b0;
        @(negedge CLK);
        bus.START = 1'b0; bus.LONG = !lng; bus.CHECK_CRC = !chk_crc;
        bus.SAMPLE_EN = 1'b0; bus.CMD_I = 1'b1;
        #1 chk("busy_after_start", bus.BUSY, 1);
    endtask

    task automatic end_frame();
        @(negedge CLK);
        bus.SAMPLE_EN = 1'b0;
        bus.CMD_I     = 1'b1;
        #1;
    endtask

    task automatic check_result(input string tag);
        chk({tag, ".done"}, bus.DONE, 1);
        chk({tag, ".busy"}, bus.BUSY, 0);
        if (e_chk_idx) chk({tag, ".index"}, bus.INDEX, e_idx);
        chk({tag, ".resp"}, bus.RESP, e_resp);
        chk({tag, ".crc_err"}, bus.CRC_ERR, e_crc);
        chk({tag, ".end_err"}, bus.END_ERR, e_end);
        chk({tag, ".tx_err"}, bus.TX_ERR, e_tx);
        chk({tag, ".to_err"}, bus.TIMEOUT_ERR, e_to);
        @(negedge CLK);
        #1;
        chk({tag, ".done_low"}, bus.DONE, 0);
        chk({tag, ".done_count"}, 128'(done_cnt), 128'(d0 + 1));
    endtask

    task automatic run(input logic lng, input logic chk_crc, input int div, input int pre,
                       input string tag);
        arm(lng, chk_crc);
        repeat (pre) drive_bit(1'b1, div);
        drive_range(1, fn, div);
        end_frame();
        check_result(tag);
    endtask

    initial begin
        RST = 1'b1;
        bus.SAMPLE_EN = 1'b0; bus.CMD_I = 1'b1; bus.START = 1'b0;
        bus.LONG = 1'b0; bus.CHECK_CRC = 1'b0; bus.ABORT = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst.busy", bus.BUSY, 0);
        chk("rst.done", bus.DONE, 0);
        chk("rst.index", bus.INDEX, 0);
        chk("rst.resp", bus.RESP, 0);
        chk("rst.errs", {bus.CRC_ERR, bus.END_ERR, bus.TX_ERR, bus.TIMEOUT_ERR}, 0);
        RST = 1'b0;

        // R3, CRC check disabled, strobe every 4th CLK
        fvec = 136'(48'h3F80FF8000FF); fn = 48;
        e_idx = 6'h3F; e_chk_idx = 1'b1; e_resp = 128'h80FF8000;
        e_crc = 1'b0; e_end = 1'b0; e_tx = 1'b0; e_to = 1'b0;
        run(1'b0, 1'b0, 4, 3, "r3");

        // R1, back-to-back strobes, good CRC then one flipped CRC bit
        prep_short(1'b0, 6'd17, 32'h00000900, 7'h00, 1'b1, 1'b1);
        run(1'b0, 1'b1, 1, 2, "r1_ok");
        prep_short(1'b0, 6'd17, 32'h00000900, 7'h04, 1'b1, 1'b1);
        run(1'b0, 1'b1, 1, 2, "r1_crc");

        // R2 long, good frame then end bit 0
        r_pay = 120'({$urandom, $urandom, $urandom, $urandom});
        prep_long(1'b0, r_pay, 7'h00, 1'b1, 1'b1);
        run(1'b1, 1'b1, 2, 1, "r2_ok");
        prep_long(1'b0, r_pay, 7'h00, 1'b0, 1'b1);
        run(1'b1, 1'b1, 1, 0, "r2_end");

        // Transmission bit 1
        prep_short(1'b1, 6'd55, 32'hDEADBEEF, 7'h00, 1'b1, 1'b1);
        run(1'b0, 1'b1, 1, 0, "txbit");

        // Timeout: DONE right after the 64th idle strobe, not before
        arm(1'b0, 1'b1);
        repeat (63) drive_bit(1'b1, 2);
        @(negedge CLK); bus.SAMPLE_EN = 1'b0; #1;
        chk("to63.busy", bus.BUSY, 1);
        chk("to63.done", bus.DONE, 0);
        chk("to63.to_err", bus.TIMEOUT_ERR, 0);
        drive_bit(1'b1, 1);
        end_frame();
        e_idx = 6'd0; e_chk_idx = 1'b1; e_resp = '0;
        e_crc = 1'b0; e_end = 1'b0; e_tx = 1'b0; e_to = 1'b1;
        check_result("timeout");

        // Start bit on the 63rd strobe
        prep_short(1'b0, 6'(($urandom)), $urandom, 7'h00, 1'b1, 1'b1);
        run(1'b0, 1'b1, 1, 62, "start63");

        // Randomized frames
        for (int t = 0; t < 8; t++) begin
            r_lng  = 1'($urandom);
            r_chk  = 1'($urandom);
            r_tx   = ($urandom_range(3) == 0);
            r_endb = ($urandom_range(3) != 0);
            r_flip = ($urandom_range(2) == 0) ? 7'(1 << $urandom_range(6)) : 7'h00;
            r_div  = 1 + $urandom_range(2);
            r_pre  = $urandom_range(9);
            if (r_lng) begin
                r_pay = 120'({$urandom, $urandom, $urandom, $urandom});
                prep_long(r_tx, r_pay, r_flip, r_endb, r_chk);
            end else begin
                prep_short(r_tx, 6'($urandom), $urandom, r_flip, r_endb, r_chk);
            end
            run(r_lng, r_chk, r_div, r_pre, $sformatf("rand%0d", t));
        end

        // START while receiving: ignored, latched LONG/CHECK_CRC kept
        prep_short(1'b0, 6'd9, 32'h12345678, 7'h10, 1'b1, 1'b1);
        arm(1'b0, 1'b1);
        drive_range(1, 10, 2);
        @(negedge CLK);
        bus.START = 1'b1; bus.LONG = 1'b1; bus.CHECK_CRC = 1'b0; bus.SAMPLE_EN = 1'b0;
        @(negedge CLK);
        bus.START = 1'b0;
        drive_range(11, 48, 2);
        end_frame();
        check_result("start_in_recv");

        // ABORT mid-frame: BUSY drops next CLK, no DONE afterwards
        prep_short(1'b0, 6'd3, 32'hA5A5A5A5, 7'h00, 1'b1, 1'b1);
        arm(1'b0, 1'b1);
        drive_range(1, 20, 1);
        @(negedge CLK); bus.SAMPLE_EN = 1'b0; bus.ABORT = 1'b1;
        @(negedge CLK); bus.ABORT = 1'b0; #1;
        chk("abort.busy", bus.BUSY, 0);
        drive_range(21, 48, 1);
        end_frame();
        @(negedge CLK); #1;
        chk("abort.done_count", 128'(done_cnt), 128'(d0));
        chk("abort.busy_end", bus.BUSY, 0);

        // ABORT in the DONE cycle suppresses the pulse
        prep_short(1'b0, 6'd5, 32'h0F0F0F0F, 7'h00, 1'b1, 1'b1);
        arm(1'b0, 1'b1);
        drive_range(1, 48, 1);
        @(negedge CLK); bus.SAMPLE_EN = 1'b0; bus.ABORT = 1'b1; #1;
        chk("abort_fin.done", bus.DONE, 0);
        @(negedge CLK); bus.ABORT = 1'b0; #1;
        chk("abort_fin.busy", bus.BUSY, 0);
        @(negedge CLK); #1;
        chk("abort_fin.done_count", 128'(done_cnt), 128'(d0));

        // ABORT together with START in IDLE: stays idle
        d0 = done_cnt;
        @(negedge CLK); bus.START = 1'b1; bus.ABORT = 1'b1;
        @(negedge CLK); bus.START = 1'b0; bus.ABORT = 1'b0; #1;
        chk("abort_start.busy", bus.BUSY, 0);
        repeat (3) drive_bit(1'b0, 1);
        end_frame();
        @(negedge CLK); #1;
        chk("abort_start.busy2", bus.BUSY, 0);
        chk("abort_start.done_count", 128'(done_cnt), 128'(d0));

        // RST mid-frame clears outputs asynchronously
        prep_short(1'b1, 6'h2A, 32'hCAFEF00D, 7'h00, 1'b1, 1'b1);
        arm(1'b0, 1'b1);
        drive_range(1, 20, 1);
        @(negedge CLK); bus.SAMPLE_EN = 1'b0; #1;
        chk("rstmid.pre_tx", bus.TX_ERR, 1);
        chk("rstmid.pre_index", bus.INDEX, 6'h2A);
        #1 RST = 1'b1;
        #1;
        chk("rstmid.busy", bus.BUSY, 0);
        chk("rstmid.index", bus.INDEX, 0);
        chk("rstmid.resp", bus.RESP, 0);
        chk("rstmid.tx", bus.TX_ERR, 0);
        @(negedge CLK); RST = 1'b0;
        drive_range(21, 48, 1);
        end_frame();
        @(negedge CLK); #1;
        chk("rstmid.done_count", 128'(done_cnt), 128'(d0));
        chk("rstmid.busy_end", bus.BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_cmd_resp_receiver.md
# sd_cmd_resp_receiver

Receives SD card responses on the CMD line, in the SD host controller's CLK domain. The command transmitter arms it after a command's end bit. It then does the following:
- waits for a start bit, bounded by an NCR timeout;
- deserializes a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response;
- checks the transmission bit, CRC7 and end bit;
- reports the result.

All sampling is qualified by a one-CLK strobe marking SD_CLK rising edges, generated by the controller's clock-divider logic.

## Interface

Parameters:
- TIMEOUT, default 64: number of SAMPLE_EN strobes without a start bit before a timeout (NCR limit).

Ports:
- CLK  in  1  system clock; all logic on posedge
- RST  in  1  reset, asynchronous, active-high
- SAMPLE_EN  in  1  one-CLK strobe, SD_CLK rising edge; CMD_I valid in this cycle
- CMD_I  in  1  CMD line, already registered into the CLK domain
- START  in  1  one-CLK pulse that arms reception; ignored unless in IDLE
- LONG  in  1  latched at START: 1 = 136-bit R2, 0 = 48-bit
- CHECK_CRC  in  1  latched at START: 0 = skip CRC7 compare (R3)
- ABORT  in  1  forces IDLE from any state; no DONE pulse
- BUSY  out  1  high in WAIT_START and RECV
- DONE  out  1  one-CLK pulse at completion, including timeout
- INDEX  out  6  command index field (short response); 6'h3F expected for long
- RESP  out  128  short: RESP[31:0] = argument, RESP[127:32] = 0; long: frame bits [127:0] after the 8-bit header
- CRC_ERR  out  1  CRC7 mismatch (valid with DONE)
- END_ERR  out  1  end bit sampled 0
- TX_ERR  out  1  transmission bit sampled 1
- TIMEOUT_ERR  out  1  no start bit within TIMEOUT strobes

## Operation

States: IDLE, WAIT_START, RECV, FINISH.
- IDLE:
  - On START: latch LONG and CHECK_CRC.
  - Clear all error flags, INDEX, RESP, the bit counter, the timeout counter and the CRC register.
  - Go to WAIT_START.
- WAIT_START, on each SAMPLE_EN:
  - CMD_I == 0: start bit. CRC-shift a 0, set bit count = 1, go to RECV.
  - Otherwise increment the timeout counter. If the increment reaches TIMEOUT, set TIMEOUT_ERR and go to FINISH.
- RECV, on each SAMPLE_EN:
  - Shift CMD_I in MSB-first and increment the bit count.
  - Bit 2 (the transmission bit) is checked: 1 sets TX_ERR.
  - Short frame, bits 3-8 go to INDEX, bits 9-40 go to the argument.
  - CRC7 (polynomial x^7+x^3+1, init 0) covers the following bits:
    - Short frame: frame bits 1-40, including start and transmission bits.
    - Long frame: RESP[127:8] only. The header is excluded.
  - The last sampled bit (48 or 136) is the end bit. End bit 0 sets END_ERR.
  - On the last bit: if CHECK_CRC, set CRC_ERR when the received CRC7 (bits 41-47 short, RESP[7:1] long) differs from the computed value. Then go to FINISH.
- FINISH: assert DONE for one CLK, go to IDLE.
- Results and error flags hold until the next accepted START.
- SAMPLE_EN is ignored in IDLE and FINISH.
- A start bit is never detected in the same CLK cycle as START.

## Timing

- Reset values:
  - State IDLE.
  - BUSY = DONE = 0.
  - INDEX = 0, RESP = 0.
  - All error flags 0.
  - All counters 0.
- START to BUSY high: 1 CLK (registered).
- DONE is high in the CLK cycle after the cycle whose SAMPLE_EN captured the end bit (or the TIMEOUT-th idle strobe). BUSY falls in that same DONE cycle.
- Error flags and RESP/INDEX are stable when DONE is high.
- Simultaneous events:
  - ABORT with START in IDLE: ABORT wins; the block stays IDLE.
  - ABORT in FINISH: the DONE pulse is suppressed.
  - START while BUSY: ignored; latched LONG/CHECK_CRC are unchanged.
- SAMPLE_EN is at most one cycle per SD bit. Back-to-back strobes (divider bypass, SAMPLE_EN tied high) must work at 1 bit per CLK.
- Counter widths: bit count 8 bits (max 136). Timeout counter is clog2(TIMEOUT+1) bits and does not wrap.
- RST mid-reception: immediate return to reset values; no DONE.

## Test plan

- Short R3, CHECK_CRC=0, frame 0x3F_80FF8000_FF, strobe every 4th CLK: DONE once. INDEX=6'h3F, RESP[31:0]=32'h80FF8000, all errors 0.
- Short R1, index 17, argument 32'h00000900, CRC7 from the bench model, CHECK_CRC=1, back-to-back strobes: no errors. Repeat with one CRC bit flipped: only CRC_ERR=1.
- Long R2 with 128-bit CID from the bench, valid CRC7 in RESP[7:1]: RESP matches bit-for-bit, no errors. Repeat with end bit 0: only END_ERR=1.
- No start bit, TIMEOUT=64: DONE exactly one CLK after the 64th strobe, TIMEOUT_ERR=1. A start bit at strobe 63 is received normally.
- Transmission bit 1: TX_ERR=1, reception completes.
- Robustness:
  - ABORT mid-frame gives BUSY=0 next CLK and no DONE.
  - A START during RECV is ignored.
  - RST asserted mid-frame clears all outputs asynchronously.
